// File: rtl/channel_pkg.sv
// Shared types and default parameters for the two-transmitter channel arbiter.
package channel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH_HI = 3'd1,
        ST_FLUSH_LO = 3'd2,
        ST_DATA_HI  = 3'd3,
        ST_DATA_LO  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef logic signed [1:0] symbol_t;

    localparam int DEF_FRAME_LEN   = 10;
    localparam int DEF_FLUSH_SYMS  = 6;
    localparam int DEF_START_WIDTH = 4;
    localparam int DEF_GAP_CYCLES  = 2;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Counts the cycles of one symbol slot: START_WIDTH high cycles then GAP_CYCLES low cycles.
module slot_timer #(
    parameter int START_WIDTH = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic hi_phase,
    output logic slot_end
);

    localparam int PERIOD = START_WIDTH + GAP_CYCLES;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // slot_end describes the current cycle; hi_phase looks ahead to the next one
    // so the arbiter can register chan_start without a cycle of lag.
    assign slot_end = (cnt == CW'(PERIOD - 1));
    assign hi_phase = (cnt_nx < CW'(START_WIDTH));

    always_comb begin
        cnt_nx = cnt + CW'(1);
        if (load || slot_end) begin
            cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin owner of the shared channel: grants fixed-length frames, drives slot-timed
// symbols, and prefixes zero symbols to flush the delay line when ownership changes.
module channel_arbiter
    import channel_pkg::*;
#(
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int START_WIDTH = DEF_START_WIDTH,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int FLUSH_SYMS  = DEF_FLUSH_SYMS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  symbol_t     sym0,
    input  symbol_t     sym1,
    output logic [1:0]  grant,
    output logic [1:0]  sym_ack,
    output logic        chan_start,
    output symbol_t     chan_sym,
    output logic        busy,
    output logic        frame_done
);

    localparam int MAX_SLOTS = (FRAME_LEN > FLUSH_SYMS) ? FRAME_LEN : FLUSH_SYMS;
    localparam int SLOT_W    = $clog2(MAX_SLOTS + 1);
    localparam logic [SLOT_W-1:0] FRAME_LAST = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] FLUSH_LAST = (FLUSH_SYMS > 0) ? SLOT_W'(FLUSH_SYMS - 1) : '0;

    state_e              state, state_nx;
    logic                owner, owner_nx;
    logic                last_owner, last_owner_nx;
    logic                flush_pending, flush_pending_nx;
    logic [SLOT_W-1:0]   slot_cnt, slot_nx;
    logic [1:0]          grant_nx, ack_nx;
    logic                start_nx, done_nx, busy_nx;
    symbol_t             sym_nx;
    logic                pick;
    logic                timer_load;
    logic                hi_phase, slot_end;

    slot_timer #(
        .START_WIDTH(START_WIDTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_slot_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .hi_phase(hi_phase),
        .slot_end(slot_end)
    );

    // With both requests pending, the transmitter that did not own the last frame wins.
    assign pick = (req == 2'b11) ? ~last_owner : req[1];

    always_comb begin
        state_nx         = state;
        owner_nx         = owner;
        last_owner_nx    = last_owner;
        flush_pending_nx = flush_pending;
        slot_nx          = slot_cnt;
        grant_nx         = grant;
        ack_nx           = 2'b00;
        start_nx         = hi_phase;
        sym_nx           = chan_sym;
        done_nx          = 1'b0;
        timer_load       = 1'b0;

        case (state)
            ST_IDLE: begin
                start_nx = 1'b0;
                if (req != 2'b00) begin
                    owner_nx         = pick;
                    last_owner_nx    = pick;
                    flush_pending_nx = 1'b0;
                    grant_nx         = onehot(pick);
                    timer_load       = 1'b1;
                    start_nx         = 1'b1;
                    slot_nx          = '0;
                    if ((flush_pending || (pick != last_owner)) && (FLUSH_SYMS > 0)) begin
                        state_nx = ST_FLUSH_HI;
                        sym_nx   = '0;
                    end else begin
                        state_nx = ST_DATA_HI;
                        sym_nx   = pick ? sym1 : sym0;
                        ack_nx   = onehot(pick);
                    end
                end
            end

            ST_FLUSH_HI, ST_FLUSH_LO: begin
                if (slot_end) begin
                    if (slot_cnt == FLUSH_LAST) begin
                        slot_nx  = '0;
                        state_nx = ST_DATA_HI;
                        sym_nx   = owner ? sym1 : sym0;
                        ack_nx   = onehot(owner);
                    end else begin
                        slot_nx  = slot_cnt + SLOT_W'(1);
                        state_nx = ST_FLUSH_HI;
                    end
                end else begin
                    state_nx = hi_phase ? ST_FLUSH_HI : ST_FLUSH_LO;
                end
            end

            ST_DATA_HI, ST_DATA_LO: begin
                if (slot_end) begin
                    if (slot_cnt == FRAME_LAST) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                        grant_nx = 2'b00;
                        sym_nx   = '0;
                        start_nx = 1'b0;
                        slot_nx  = '0;
                    end else begin
                        slot_nx  = slot_cnt + SLOT_W'(1);
                        state_nx = ST_DATA_HI;
                        sym_nx   = owner ? sym1 : sym0;
                        ack_nx   = onehot(owner);
                    end
                end else begin
                    state_nx = hi_phase ? ST_DATA_HI : ST_DATA_LO;
                end
            end

            ST_DONE: begin
                start_nx = 1'b0;
                state_nx = ST_IDLE;
            end

            default: begin
                start_nx = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            flush_pending <= 1'b1;
            slot_cnt      <= '0;
            grant         <= 2'b00;
            sym_ack       <= 2'b00;
            chan_start    <= 1'b0;
            chan_sym      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            last_owner    <= last_owner_nx;
            flush_pending <= flush_pending_nx;
            slot_cnt      <= slot_nx;
            grant         <= grant_nx;
            sym_ack       <= ack_nx;
            chan_start    <= start_nx;
            chan_sym      <= sym_nx;
            busy          <= busy_nx;
            frame_done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: default instance plus a minimal-timing, no-flush instance.
module tb_channel_arbiter;
    import channel_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    symbol_t    sym0, sym1;

    logic [1:0] grant_a, ack_a, grant_b, ack_b;
    logic       start_a, busy_a, done_a, start_b, busy_b, done_b;
    symbol_t    csym_a, csym_b;

    logic       sel;
    int         cur_sw, cur_gap, cur_flush;
    int         vec_count = 0;
    int         err_count = 0;
    symbol_t    exp_q[$];
    logic [8:0] obs_vec;

    always #5 clk = ~clk;

    channel_arbiter dut_a (
        .clk(clk), .reset(reset), .req(req), .sym0(sym0), .sym1(sym1),
        .grant(grant_a), .sym_ack(ack_a), .chan_start(start_a), .chan_sym(csym_a),
        .busy(busy_a), .frame_done(done_a)
    );

    channel_arbiter #(.FRAME_LEN(10), .START_WIDTH(1), .GAP_CYCLES(1), .FLUSH_SYMS(0)) dut_b (
        .clk(clk), .reset(reset), .req(req), .sym0(sym0), .sym1(sym1),
        .grant(grant_b), .sym_ack(ack_b), .chan_start(start_b), .chan_sym(csym_b),
        .busy(busy_b), .frame_done(done_b)
    );

    assign obs_vec = sel ? {grant_b, ack_b, start_b, csym_b, busy_b, done_b}
                         : {grant_a, ack_a, start_a, csym_a, busy_a, done_a};

    function automatic logic [8:0] pack(input logic [1:0] g, input logic [1:0] a, input logic s,
                                        input symbol_t y, input logic b, input logic d);
        return {g, a, s, y, b, d};
    endfunction

    function automatic symbol_t pat(input int k, input bit vary);
        if (!vary) return 2'sd1;
        case (k % 3)
            0:       return 2'sd1;
            1:       return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic rst);
        req   = r;
        reset = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        vec_count++;
        assert (observed === expected)
        else begin
            err_count++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // The non-owner gets the opposite symbol so a wrong-source capture shows up.
    task automatic set_owner_sym(input int own, input symbol_t v);
        if (own == 1) begin
            sym1 = v;
            sym0 = -v;
        end else begin
            sym0 = v;
            sym1 = -v;
        end
    endtask

    // Runs one frame from the granting edge; expected symbols queue up as they are driven
    // and are popped at each slot where the owner's symbol should be captured.
    task automatic run_frame(input int own, input bit flushed, input bit vary,
                             input int drop_at, input int abort_slot, input logic [1:0] req_after);
        int         p, nflush, total, pos, k, acks;
        logic [1:0] g, a;
        symbol_t    cur, ys;
        p      = cur_sw + cur_gap;
        nflush = flushed ? cur_flush : 0;
        total  = (nflush + 10) * p;
        g      = (own == 1) ? 2'b10 : 2'b01;
        cur    = 2'sd0;
        k      = 0;
        acks   = 0;
        exp_q.delete();
        set_owner_sym(own, pat(0, vary));
        exp_q.push_back(pat(0, vary));
        tick();
        for (int n = 0; n < total; n++) begin
            pos = n % p;
            a   = 2'b00;
            if (n >= nflush * p && pos == 0) begin
                a = g;
                acks++;
                if (exp_q.size() > 0) cur = exp_q.pop_front();
            end
            ys = (n >= nflush * p) ? cur : 2'sd0;
            checkOutput($sformatf("own%0d cyc%0d", own, n), obs_vec,
                        pack(g, a, (pos < cur_sw), ys, 1'b1, 1'b0));
            if (a != 2'b00) begin
                if (abort_slot >= 0 && acks == abort_slot + 1) begin
                    reset = 1'b1;
                    tick();
                    checkOutput("abort reset", obs_vec, 9'd0);
                    reset = 1'b0;
                    exp_q.delete();
                    return;
                end
                if (acks == drop_at) begin
                    req[own]     = 1'b0;
                    req[1 - own] = 1'b1;
                end
                k++;
                if (k < 10) begin
                    set_owner_sym(own, pat(k, vary));
                    exp_q.push_back(pat(k, vary));
                end
            end
            tick();
        end
        checkOutput($sformatf("own%0d done", own), obs_vec,
                    pack(2'b00, 2'b00, 1'b0, 2'sd0, 1'b1, 1'b1));
        tick();
        checkOutput($sformatf("own%0d idle", own), obs_vec, 9'd0);
        req = req_after;
    endtask

    initial begin
        sel       = 1'b0;
        cur_sw    = 4;
        cur_gap   = 2;
        cur_flush = 6;
        sym0      = 2'sd0;
        sym1      = 2'sd0;

        applyStimulus(2'b00, 1'b1);
        tick();
        tick();
        checkOutput("reset state", obs_vec, 9'd0);

        $display("[TB] single requester, +1 held, flushed frame");
        applyStimulus(2'b01, 1'b0);
        run_frame(0, 1'b1, 1'b0, -1, -1, 2'b00);

        $display("[TB] simultaneous requests after reset");
        applyStimulus(2'b00, 1'b1);
        tick();
        checkOutput("reset 2", obs_vec, 9'd0);
        applyStimulus(2'b11, 1'b0);
        run_frame(0, 1'b1, 1'b1, -1, -1, 2'b11);
        run_frame(1, 1'b1, 1'b1, -1, -1, 2'b11);
        run_frame(0, 1'b1, 1'b1, -1, -1, 2'b00);

        $display("[TB] same owner twice: flushed then unflushed");
        applyStimulus(2'b00, 1'b1);
        tick();
        checkOutput("reset 3", obs_vec, 9'd0);
        applyStimulus(2'b01, 1'b0);
        run_frame(0, 1'b1, 1'b1, -1, -1, 2'b01);
        run_frame(0, 1'b0, 1'b1, -1, -1, 2'b00);

        $display("[TB] owner drops req, other raises it mid-frame");
        applyStimulus(2'b01, 1'b0);
        run_frame(0, 1'b0, 1'b1, 3, -1, 2'b10);
        run_frame(1, 1'b1, 1'b1, -1, -1, 2'b00);

        $display("[TB] reset during data slot 5");
        applyStimulus(2'b01, 1'b0);
        run_frame(0, 1'b1, 1'b1, -1, 5, 2'b01);
        run_frame(0, 1'b1, 1'b1, -1, -1, 2'b00);

        $display("[TB] no-flush, one-cycle phases instance");
        applyStimulus(2'b00, 1'b1);
        tick();
        sel       = 1'b1;
        cur_sw    = 1;
        cur_gap   = 1;
        cur_flush = 0;
        #1;
        checkOutput("reset b", obs_vec, 9'd0);
        applyStimulus(2'b01, 1'b0);
        run_frame(0, 1'b1, 1'b1, -1, -1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
